// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC owner and instruction fetch controller with a registered
//            valid/ready output stage, redirect, halt/resume and fault.
//            Optional feature macro: FETCH_BOUNDS_CHECK_EN (PC range check).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] START_ADDRESS = 32'h00001000,
    parameter int          MEM_WORDS     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam logic [1:0] c_boot  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_halt  = 2'd2;
    localparam logic [1:0] c_fault = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_instr_valid;
    logic [31:0] r_instr_out;
    logic [31:0] r_instr_pc;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic        w_load;
    logic        w_misaligned;
    logic        w_bound_fault;
    logic [1:0]  w_redirect_state;

    assign w_load       = !r_instr_valid || instr_ready;
    assign w_misaligned = (redirect_target[1:0] != 2'b00);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] c_fetch_limit = START_ADDRESS + 32'(4 * MEM_WORDS);
    assign w_bound_fault = (r_pc < START_ADDRESS) || (r_pc >= c_fetch_limit);
`else
    assign w_bound_fault = 1'b0;
`endif

    // State reached after an aligned redirect; halt/resume still apply.
    always_comb begin
        w_redirect_state = c_run;
        case (r_state)
            c_run:   w_redirect_state = halt_req ? c_halt : c_run;
            c_halt:  w_redirect_state = (resume && !halt_req) ? c_run : c_halt;
            default: w_redirect_state = c_run;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_boot;
            r_pc          <= START_ADDRESS;
            r_instr_valid <= 1'b0;
            r_instr_out   <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_fault       <= 1'b0;
            r_fault_pc    <= 32'd0;
        end else if (r_state != c_fault && redirect_valid) begin
            // Held fetch is discarded regardless of whether it was accepted.
            r_instr_valid <= 1'b0;
            if (w_misaligned) begin
                r_state    <= c_fault;
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_target;
            end else begin
                r_pc    <= redirect_target;
                r_state <= w_redirect_state;
            end
        end else begin
            case (r_state)
                c_boot: begin
                    r_state <= c_run;
                end
                c_run: begin
                    if (halt_req) begin
                        r_state <= c_halt;
                        if (instr_ready) begin
                            r_instr_valid <= 1'b0;
                        end
                    end else if (w_load) begin
                        if (w_bound_fault) begin
                            r_state       <= c_fault;
                            r_fault       <= 1'b1;
                            r_fault_pc    <= r_pc;
                            r_instr_valid <= 1'b0;
                        end else begin
                            r_instr_out   <= imem_data;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= r_pc + 32'd4;
                        end
                    end
                end
                c_halt: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                    end
                    if (resume && !halt_req) begin
                        r_state <= c_run;
                    end
                end
                default: begin
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Directed checks plus randomized stream scoreboard for
//            fetch_sequencer (honours FETCH_BOUNDS_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] C_START = 32'h00001000;
    localparam int          C_WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [0:C_WORDS-1];

    int vectors    = 0;
    int miscompares = 0;
    int handshakes = 0;
    bit sb_en      = 1'b0;
    logic [63:0] exp_q [$];

    fetch_sequencer #(
        .START_ADDRESS(C_START),
        .MEM_WORDS    (C_WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .resume         (resume),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // Memory wraps on its depth, so out-of-range addresses still return data.
    function automatic logic [4:0] word_idx(input logic [31:0] a);
        logic [31:0] d;
        d = a - C_START;
        return d[6:2];
    endfunction

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return mem[word_idx(a)];
    endfunction

    assign imem_data = mem_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Consumer-side monitor: every accepted handshake must match the stream.
    always @(negedge clk) begin
        if (sb_en && rst_n && instr_valid && instr_ready) begin
            handshakes++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_underflow: got pc 0x%08h expected no transfer", instr_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({instr_pc, instr_out} !== e) begin
                    miscompares++;
                    $display("FAIL sb_stream: got pc 0x%08h data 0x%08h expected pc 0x%08h data 0x%08h",
                             instr_pc, instr_out, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] next_push;
        logic [31:0] last_pc;
        bit          last_seen;
        int          seg;

        for (int i = 0; i < C_WORDS; i++) mem[i] = $urandom;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        halt_req = 1'b0; resume = 1'b0; instr_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_imem_addr", imem_addr, C_START);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        rst_n = 1'b1;

        // Boot cycle, then sequential fetch
        step(); chk("boot_no_valid", {31'd0, instr_valid}, 32'd0);
        step(); chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_pc", instr_pc, 32'h1000); chk("first_data", instr_out, mem[0]);
        step(); chk("seq_pc1", instr_pc, 32'h1004); chk("seq_data1", instr_out, mem[1]);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", instr_pc, 32'h1004);
            chk("stall_data", instr_out, mem[1]);
            chk("stall_addr", imem_addr, 32'h1008);
        end
        instr_ready = 1'b1;
        step(); chk("seq_pc2", instr_pc, 32'h1008); chk("seq_data2", instr_out, mem[2]);
        chk("seq_fault", {31'd0, fault}, 32'd0);

        // Redirect while 0x1008 is held and unaccepted
        instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h1010;
        step(); redirect_valid = 1'b0; instr_ready = 1'b1;
        chk("redir_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h1010);
        step(); chk("redir_pc", instr_pc, 32'h1010); chk("redir_data", instr_out, mem[4]);
        chk("redir_valid", {31'd0, instr_valid}, 32'd1);

        // Halt pulse: held instruction consumed, then nothing until resume
        halt_req = 1'b1;
        step(); halt_req = 1'b0;
        chk("halt_valid0", {31'd0, instr_valid}, 32'd0);
        step(); chk("halt_valid1", {31'd0, instr_valid}, 32'd0);
        resume = 1'b1;
        step(); resume = 1'b0;
        chk("resume_valid", {31'd0, instr_valid}, 32'd0);
        step(); chk("resume_pc", instr_pc, 32'h1014);
        chk("resume_data", instr_out, mem[5]);

        // Misaligned redirect faults; later commands are ignored
        redirect_valid = 1'b1; redirect_target = 32'h1006;
        step(); redirect_valid = 1'b0;
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_pc", fault_pc, 32'h1006);
        chk("fault_valid", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_target = 32'h1020; resume = 1'b1;
        step(); step();
        redirect_valid = 1'b0; resume = 1'b0;
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_pc_frozen", fault_pc, 32'h1006);
        chk("fault_no_issue", {31'd0, instr_valid}, 32'd0);

        // Asynchronous reset mid-cycle
        #3 rst_n = 1'b0;
        #1;
        chk("arst_fault", {31'd0, fault}, 32'd0);
        chk("arst_fault_pc", fault_pc, 32'd0);
        chk("arst_addr", imem_addr, C_START);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);

        // Randomized phase with stream scoreboard
        step(); step();
        exp_q.delete();
        next_push = C_START;
        sb_en = 1'b1;
        rst_n = 1'b1;
        seg = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (seg >= 8 || $urandom_range(0, 9) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = C_START + 32'(4 * $urandom_range(0, 15));
                instr_ready     = 1'b0;
                halt_req        = ($urandom_range(0, 3) == 0);
                resume          = ($urandom_range(0, 1) == 0);
                exp_q.delete();
                next_push = redirect_target;
                seg = 0;
            end else begin
                redirect_valid = 1'b0;
                instr_ready    = ($urandom_range(0, 3) != 0);
                halt_req       = ($urandom_range(0, 15) == 0);
                resume         = ($urandom_range(0, 3) == 0);
                seg++;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back({next_push, mem_at(next_push)});
                next_push = next_push + 32'd4;
            end
            step();
        end
        redirect_valid = 1'b0; halt_req = 1'b0; resume = 1'b0; instr_ready = 1'b0;
        step();
        sb_en = 1'b0;
        chk("rand_progress", {31'd0, handshakes >= 100}, 32'd1);
        chk("rand_no_fault", {31'd0, fault}, 32'd0);

        // Sequential run off the end of memory
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; instr_ready = 1'b1;
        last_pc = 32'd0; last_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (instr_valid) begin
                last_pc = instr_pc;
                last_seen = 1'b1;
            end
            if (fault || (last_seen && last_pc == 32'h1080)) break;
        end
`ifdef FETCH_BOUNDS_CHECK_EN
        chk("bound_fault", {31'd0, fault}, 32'd1);
        chk("bound_fault_pc", fault_pc, 32'h1080);
        chk("bound_last_pc", last_pc, 32'h107C);
        chk("bound_no_issue", {31'd0, instr_valid}, 32'd0);
`else
        chk("nobound_pc", last_pc, 32'h1080);
        chk("nobound_data", instr_out, mem[0]);
        chk("nobound_fault", {31'd0, fault}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller for the single-cycle core. It owns the program counter and drives the combinational instruction memory read port. It presents each fetched word with its PC to decode through a registered valid/ready handshake. It handles redirects from branch/jump resolution, external halt/resume, and fetch faults.

## Interface
Parameters:
- START_ADDRESS, 32'h00001000, reset vector and base of instruction memory
- MEM_WORDS, 32, instruction memory depth in 32-bit words

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- imem_addr  output  32  byte address to instruction memory read_address
- imem_data  input  32  instruction word from memory read_data (same-cycle, combinational)
- redirect_valid  input  1  load new PC this cycle
- redirect_target  input  32  new PC byte address
- halt_req  input  1  stop issuing instructions
- resume  input  1  leave HALT
- instr_valid  output  1  instr_out/instr_pc hold a valid fetch
- instr_ready  input  1  consumer accepts the current fetch
- instr_out  output  32  fetched instruction word
- instr_pc  output  32  byte address of instr_out
- fault  output  1  sticky fetch fault flag
- fault_pc  output  32  address that caused the fault

## Operation
- imem_addr = pc, combinational from the PC register.
- State machine:
  - BOOT: one cycle after reset release; no load.
  - BOOT → RUN unconditionally.
  - RUN → HALT on halt_req.
  - HALT → RUN on resume with halt_req low.
  - RUN/HALT → FAULT on fault condition.
  - FAULT is terminal until reset.
- Load condition, RUN only: `load = !instr_valid || instr_ready`. On load:
  - instr_out <= imem_data
  - instr_pc <= pc
  - instr_valid <= 1
  - pc <= pc + 4, wrapping mod 2^32
- In RUN without load: all outputs and pc hold. Contents must not change while instr_valid=1 and instr_ready=0.
- Consumption without a new load (HALT, or redirect cycle): instr_valid <= 0 when instr_ready=1.
- Redirect (any non-FAULT state, highest priority):
  - pc <= redirect_target.
  - instr_valid <= 0 next cycle, discarding the held fetch whether or not it was accepted.
  - No load that cycle.
- Misaligned redirect (redirect_target[1:0] != 0):
  - Go to FAULT.
  - fault <= 1, fault_pc <= redirect_target.
  - instr_valid <= 0.
- Simultaneous events:
  - redirect + halt_req: both apply; pc <= target, valid cleared, state HALT.
  - halt_req + resume while in HALT: stay HALT.
  - halt_req in RUN: that cycle's load is suppressed; the held instruction stays valid until consumed.
- FAULT: no loads. pc, fault and fault_pc frozen. A held instruction is dropped (instr_valid <= 0). redirect, halt_req and resume are ignored.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Any in-flight fetch is lost.

## Timing
- Reset values:
  - pc = START_ADDRESS, so imem_addr = START_ADDRESS
  - instr_valid = 0, instr_out = 0, instr_pc = 0
  - fault = 0, fault_pc = 0
  - state = BOOT
- First instr_valid=1 appears after the 2nd rising edge following rst_n release, with instr_pc = START_ADDRESS.
- Latency: one cycle from address presentation to registered output.
- Throughput: one instruction per cycle while instr_ready=1.
- Redirect taken at edge N:
  - instr_valid=0 after edge N.
  - First instruction from the target is valid after edge N+1.
- Fault is visible after the edge that detects it and stays asserted until reset.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - Before a load, check that pc lies in [START_ADDRESS, START_ADDRESS + 4*MEM_WORDS).
  - Out of range → FAULT instead of the load; fault_pc <= pc; no instruction issued.
  - Redirect targets are checked the same way at the edge they would be fetched.
- FETCH_BOUNDS_CHECK_EN undefined:
  - No range check; out-of-range PCs are fetched and issued as-is.
  - Only misaligned redirects fault.

## Test plan
- Reset, instr_ready=1 held for 4 cycles after release → instr_pc sequence 0x1000, 0x1004, 0x1008; instr_out matches memory words 0–2; fault=0.
- Hold instr_ready=0 for 3 cycles with instr_valid=1 at pc 0x1004 → instr_out/instr_pc stable, imem_addr stays 0x1008. Raise ready → next instr_pc=0x1008.
- redirect_valid=1, redirect_target=0x1010 while instr_pc=0x1008 is valid and unaccepted → next cycle instr_valid=0, following cycle instr_pc=0x1010.
- halt_req pulse in RUN → held instruction consumed once, then instr_valid stays 0. resume → fetch continues at the next sequential PC.
- redirect_target=0x1006 → fault=1, fault_pc=0x1006, instr_valid=0; further redirect/resume ignored; rst_n low clears fault.
- With FETCH_BOUNDS_CHECK_EN: run sequentially to 0x1080 → fault=1, fault_pc=0x1080, last valid instr_pc=0x107C. Without the macro, instr_pc=0x1080 issues with fault=0.
